// File: rtl/seq_run_detector_if.sv
// Bus bundle for seq_run_detector: control/serial inputs and all debug/status outputs.
//   enable, sequential_input, clear_count : driven by the master (bench / board logic)
//   current_state, next_state, run_count,
//   success_output, success_reg,
//   count_z, count_sat                    : driven by the detector (slave)
interface seq_run_detector_if #(
    parameter int unsigned CNT_W = 6
);
    logic             enable;
    logic             sequential_input;
    logic             clear_count;
    logic [1:0]       current_state;
    logic [1:0]       next_state;
    logic [3:0]       run_count;
    logic             success_output;
    logic             success_reg;
    logic [CNT_W-1:0] count_z;
    logic             count_sat;

    modport master (
        output enable, sequential_input, clear_count,
        input  current_state, next_state, run_count,
        input  success_output, success_reg, count_z, count_sat
    );

    modport slave (
        input  enable, sequential_input, clear_count,
        output current_state, next_state, run_count,
        output success_output, success_reg, count_z, count_sat
    );
endinterface

// File: rtl/seq_run_detector.sv
// Mealy detector for RUN_LEN consecutive 1s on a serial stream, with optional
// post-match hold-off (DELAY) or overlapping matches (OVERLAP), plus a
// saturating match counter.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_run_detector_if.slave (enable, sequential_input, clear_count in;
//            current_state, next_state, run_count, success_output, success_reg,
//            count_z, count_sat out). next_state and success_output are combinational.
module seq_run_detector #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned DELAY   = 0,
    parameter int unsigned OVERLAP = 0,
    parameter int unsigned CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_run_detector_if.slave bus
);

    localparam int unsigned HOLD_W     = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
    localparam logic [3:0]  LAST_RUN   = 4'(RUN_LEN - 1);
    localparam logic        SAT_AT_ONE = (CNT_W == 1);

    // Reject parameter combinations the datapath cannot honour.
    if (RUN_LEN < 1 || RUN_LEN > 15) begin : g_bad_run_len
        $fatal(1, "seq_run_detector: RUN_LEN must be in 1..15");
    end
    if (OVERLAP != 0 && DELAY != 0) begin : g_bad_overlap
        $fatal(1, "seq_run_detector: DELAY must be 0 when OVERLAP=1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        run_count;
    logic [3:0]        run_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic              match;
    logic [CNT_W-1:0]  count_z;
    logic [CNT_W-1:0]  count_inc;
    logic              count_sat;
    logic              success_reg;

    // Next-state and Mealy match; reset held keeps everything parked in IDLE.
    always_comb begin
        state_nx = state;
        run_nx   = run_count;
        hold_nx  = hold_cnt;
        match    = rst_n & bus.enable & bus.sequential_input &
                   (state != HOLD) & (run_count == LAST_RUN);

        if (rst_n && bus.enable) begin
            if (match) begin
                if (OVERLAP != 0) begin
                    // Keep the run primed so every further 1 matches again.
                    if (RUN_LEN == 1) begin
                        state_nx = IDLE;
                        run_nx   = 4'd0;
                    end else begin
                        state_nx = RUN;
                        run_nx   = LAST_RUN;
                    end
                end else if (DELAY == 0) begin
                    state_nx = IDLE;
                    run_nx   = 4'd0;
                end else begin
                    state_nx = HOLD;
                    run_nx   = 4'd0;
                    hold_nx  = HOLD_W'(DELAY);
                end
            end else begin
                case (state)
                    IDLE, RUN: begin
                        if (bus.sequential_input) begin
                            state_nx = RUN;
                            run_nx   = run_count + 4'd1;
                        end else begin
                            state_nx = IDLE;
                            run_nx   = 4'd0;
                        end
                    end
                    HOLD: begin
                        // Last hold cycle when the counter reads 1.
                        if (hold_cnt <= HOLD_W'(1)) begin
                            state_nx = IDLE;
                            hold_nx  = '0;
                        end else begin
                            hold_nx  = hold_cnt - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        run_nx   = 4'd0;
                        hold_nx  = '0;
                    end
                endcase
            end
        end
    end

    // State, run and hold registers; enable gating lives in the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_count <= 4'd0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            run_count <= run_nx;
            hold_cnt  <= hold_nx;
        end
    end

    assign count_inc = count_z + CNT_W'(1);

    // Saturating match counter with sticky saturation flag; clear wins but still counts a coincident match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_z   <= '0;
            count_sat <= 1'b0;
        end else if (bus.clear_count) begin
            count_z   <= match ? CNT_W'(1) : '0;
            count_sat <= match & SAT_AT_ONE;
        end else if (match && !(&count_z)) begin
            count_z <= count_inc;
            if (&count_inc) begin
                count_sat <= 1'b1;
            end
        end
    end

    // Delayed copy of the match flag; frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            success_reg <= 1'b0;
        end else if (bus.enable) begin
            success_reg <= match;
        end
    end

    assign bus.current_state  = state;
    assign bus.next_state     = state_nx;
    assign bus.run_count      = run_count;
    assign bus.success_output = match;
    assign bus.success_reg    = success_reg;
    assign bus.count_z        = count_z;
    assign bus.count_sat      = count_sat;

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench for seq_run_detector: four configurations share one stimulus
// stream (A defaults, B overlap, C DELAY=2, D CNT_W=2 with overlap).
// Packed vectors put DUT A in the low slice and D in the high slice.
module tb_seq_run_detector;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic din;
    logic clr;

    always #5 clk = ~clk;

    seq_run_detector_if #(.CNT_W(6)) if_a ();
    seq_run_detector_if #(.CNT_W(6)) if_b ();
    seq_run_detector_if #(.CNT_W(6)) if_c ();
    seq_run_detector_if #(.CNT_W(2)) if_d ();

    assign if_a.enable = enable;  assign if_a.sequential_input = din;  assign if_a.clear_count = clr;
    assign if_b.enable = enable;  assign if_b.sequential_input = din;  assign if_b.clear_count = clr;
    assign if_c.enable = enable;  assign if_c.sequential_input = din;  assign if_c.clear_count = clr;
    assign if_d.enable = enable;  assign if_d.sequential_input = din;  assign if_d.clear_count = clr;

    seq_run_detector #(.RUN_LEN(3), .DELAY(0), .OVERLAP(0), .CNT_W(6)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    seq_run_detector #(.RUN_LEN(3), .DELAY(0), .OVERLAP(1), .CNT_W(6)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    seq_run_detector #(.RUN_LEN(3), .DELAY(2), .OVERLAP(0), .CNT_W(6)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    seq_run_detector #(.RUN_LEN(3), .DELAY(0), .OVERLAP(1), .CNT_W(2)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    logic [3:0]  so_v, sr_v, sat_v;
    logic [7:0]  cs_v, ns_v;
    logic [15:0] rc_v;
    logic [23:0] cz_v;

    assign so_v  = {if_d.success_output, if_c.success_output, if_b.success_output, if_a.success_output};
    assign sr_v  = {if_d.success_reg, if_c.success_reg, if_b.success_reg, if_a.success_reg};
    assign sat_v = {if_d.count_sat, if_c.count_sat, if_b.count_sat, if_a.count_sat};
    assign cs_v  = {if_d.current_state, if_c.current_state, if_b.current_state, if_a.current_state};
    assign ns_v  = {if_d.next_state, if_c.next_state, if_b.next_state, if_a.next_state};
    assign rc_v  = {if_d.run_count, if_c.run_count, if_b.run_count, if_a.run_count};
    assign cz_v  = {6'(if_d.count_z), if_c.count_z, if_b.count_z, if_a.count_z};

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] sb_q[$];
    logic [3:0] reg_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_dut(input int d, input logic [1:0] st, input logic [3:0] rc,
                             input logic [5:0] cnt, input logic sat);
        check($sformatf("dut%0d current_state", d), 32'(cs_v[2*d +: 2]), 32'(st));
        check($sformatf("dut%0d run_count", d),     32'(rc_v[4*d +: 4]), 32'(rc));
        check($sformatf("dut%0d count_z", d),       32'(cz_v[6*d +: 6]), 32'(cnt));
        check($sformatf("dut%0d count_sat", d),     32'(sat_v[d]),       32'(sat));
    endtask

    // One clock of stimulus; exp_so is the expected success_output per DUT.
    task automatic step(input logic en, input logic bit_in, input logic cl, input logic [3:0] exp_so);
        logic [3:0] e;
        @(negedge clk);
        enable = en;
        din    = bit_in;
        clr    = cl;
        sb_q.push_back(exp_so);
        #1;
        e = sb_q.pop_front();
        check("success_output", 32'(so_v), 32'(e));
        @(posedge clk);
        #1;
        if (en) reg_exp = e;
        check("success_reg", 32'(sr_v), 32'(reg_exp));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;
        #1;
        reg_exp = 4'h0;
        check("reset current_state", 32'(cs_v), 32'h0);
        check("reset run_count", 32'(rc_v), 32'h0);
        check("reset count_z", 32'(cz_v), 32'h0);
        check("reset success_reg", 32'(sr_v), 32'h0);
        check("reset success_output", 32'(so_v), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        enable  = 1'b1;
        din     = 1'b1;
        clr     = 1'b0;
        reg_exp = 4'h0;
        #2 rst_n = 1'b0;

        // Reset held for 3 cycles while 1s are driven.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst success_output", 32'(so_v), 32'h0);
            check("rst next_state", 32'(ns_v), 32'h0);
            check("rst current_state", 32'(cs_v), 32'h0);
            check("rst run_count", 32'(rc_v), 32'h0);
            check("rst success_reg", 32'(sr_v), 32'h0);
            check("rst count_z", 32'(cz_v), 32'h0);
            check("rst count_sat", 32'(sat_v), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        din   = 1'b0;

        // 0,0,0,1,1,1,0 plus a trailing 0 to let the DELAY unit leave HOLD.
        step(1, 0, 0, 4'h0); step(1, 0, 0, 4'h0); step(1, 0, 0, 4'h0);
        check("post-release state", 32'(cs_v), 32'h0);
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0); step(1, 1, 0, 4'hF);
        step(1, 0, 0, 4'h0); step(1, 0, 0, 4'h0);
        for (int d = 0; d < 4; d++) check_dut(d, S_IDLE, 4'd0, 6'd1, 1'b0);

        // Seven 1s: plain matches on 3,6; overlap on 3..7; hold-off matches only on 3.
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0); step(1, 1, 0, 4'hF);
        step(1, 1, 0, 4'hA);
        check_dut(2, S_HOLD, 4'd0, 6'd2, 1'b0);
        step(1, 1, 0, 4'hA);
        step(1, 1, 0, 4'hB);
        check_dut(2, S_RUN, 4'd1, 6'd2, 1'b0);
        step(1, 1, 0, 4'hA);
        step(1, 0, 0, 4'h0);
        check_dut(0, S_IDLE, 4'd0, 6'd3, 1'b0);
        check_dut(1, S_IDLE, 4'd0, 6'd6, 1'b0);
        check_dut(2, S_IDLE, 4'd0, 6'd2, 1'b0);
        check_dut(3, S_IDLE, 4'd0, 6'd3, 1'b1);

        // clear_count coinciding with a match.
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0); step(1, 1, 1, 4'hF);
        check_dut(0, S_IDLE, 4'd0, 6'd1, 1'b0);
        check_dut(1, S_RUN,  4'd2, 6'd1, 1'b0);
        check_dut(2, S_HOLD, 4'd0, 6'd1, 1'b0);
        check_dut(3, S_RUN,  4'd2, 6'd1, 1'b0);
        step(1, 0, 0, 4'h0); step(1, 0, 0, 4'h0);
        for (int d = 0; d < 4; d++) check_dut(d, S_IDLE, 4'd0, 6'd1, 1'b0);

        // Two 1s, four disabled cycles, then the third 1 still matches.
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0);
        step(0, 0, 0, 4'h0); step(0, 1, 0, 4'h0); step(0, 0, 0, 4'h0); step(0, 1, 0, 4'h0);
        check("frozen next_state", 32'(ns_v), 32'h55);
        for (int d = 0; d < 4; d++) check_dut(d, S_RUN, 4'd2, 6'd1, 1'b0);
        step(1, 1, 0, 4'hF);
        check("count after frozen run", 32'(cz_v), 32'h082082);
        // Disabled clear: counters clear, success_reg and HOLD stay frozen.
        step(0, 0, 1, 4'h0);
        check("disabled clear count_z", 32'(cz_v), 32'h0);
        check("disabled next_state", 32'(ns_v), 32'h74);
        check_dut(2, S_HOLD, 4'd0, 6'd0, 1'b0);
        step(1, 0, 0, 4'h0); step(1, 0, 0, 4'h0);
        check("idle after drain", 32'(cs_v), 32'h0);

        // Two 1s, reset pulse, three fresh 1s -> one match on the third.
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0);
        check("pre-reset run_count", 32'(rc_v), 32'h2222);
        reset_pulse();
        step(1, 1, 0, 4'h0); step(1, 1, 0, 4'h0); step(1, 1, 0, 4'hF);
        check("post-reset counts", 32'(cz_v), 32'h041041);
        check_dut(2, S_HOLD, 4'd0, 6'd1, 1'b0);

        // Reset during HOLD aborts it; next 1 starts a new run.
        reset_pulse();
        step(1, 1, 0, 4'h0);
        for (int d = 0; d < 4; d++) check_dut(d, S_RUN, 4'd1, 6'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
